// File: rtl/si_channel_statistics_wb_if.sv
// Sniffed AXI-stream tags plus Wishbone slave bus for the per-channel statistics block.
interface si_channel_statistics_wb_if #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  axis_tvalid;
    logic                  axis_tready;
    logic [DATA_WIDTH-1:0] axis_tdata;
    logic [KEEP_WIDTH-1:0] axis_tkeep;

    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic [31:0]           wb_dat_i;
    logic                  wb_we_i;
    logic                  wb_stb_i;
    logic                  wb_cyc_i;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_o;

    modport master (
        output axis_tvalid, axis_tready, axis_tdata, axis_tkeep,
        output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  axis_tvalid, axis_tready, axis_tdata, axis_tkeep,
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/si_channel_statistics_wb.sv
// Passive per-channel time-tag statistics: totals, gated rates, overflow flag and out-of-range count.
// Two-stage pipeline (lane decode, then per-channel accumulate), Wishbone register access.
module si_channel_statistics_wb #(
    parameter int DATA_WIDTH   = 128,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int NUM_CHANNELS = 8,
    parameter int CNT_WIDTH    = 32,
    parameter int CLK_FREQ     = 333333333,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    si_channel_statistics_wb_if.slave bus
);
    localparam int          LANES    = DATA_WIDTH / 32;
    localparam int          LCW      = $clog2(LANES + 1);
    localparam logic [31:0] GATE_RST = 32'(CLK_FREQ - 1);
    localparam logic [31:0] GATE_MIN = 32'd15;

    // stage 1: per-lane decode
    logic [LANES-1:0] s1_vld_q, s1_vld_d;
    logic [5:0]       s1_ch_q [LANES];
    logic [5:0]       s1_ch_d [LANES];
    logic             s1_ovf_q, s1_ovf_d;

    // stage 2 state and registers
    logic [CNT_WIDTH-1:0] total_q   [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] total_d   [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] rate_q    [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] rate_d    [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] latched_q [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] latched_d [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] rate_sat  [NUM_CHANNELS];
    logic [LCW-1:0]       lane_cnt  [NUM_CHANNELS];
    logic [LCW-1:0]       oor_cnt;
    logic [CNT_WIDTH-1:0] oor_q, oor_d;
    logic                 ovf_q, ovf_d;
    logic [1:0]           control_q, control_d;
    logic [2:0]           clr_q, clr_d;
    logic [31:0]          gate_q, gate_d;
    logic [31:0]          timer_q, timer_d;
    logic                 expire;
    logic                 en;

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        req, wr;
    logic [31:0] adr_w;
    logic [31:0] rdata;
    logic [31:0] gate_wval;

    always_comb begin
        s1_ovf_d = 1'b0;
        s1_vld_d = '0;
        for (int l = 0; l < LANES; l++) begin
            s1_ch_d[l] = bus.axis_tdata[32*l+24 +: 6];
            if (bus.axis_tvalid && bus.axis_tready && bus.axis_tkeep[4*l+3]) begin
                if (bus.axis_tdata[32*l+30 +: 2] == 2'b01) s1_vld_d[l] = 1'b1;
                if (bus.axis_tdata[32*l+30 +: 2] == 2'b10) s1_ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        oor_cnt = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            lane_cnt[c] = '0;
            for (int l = 0; l < LANES; l++) begin
                if (s1_vld_q[l] && (s1_ch_q[l] == 6'(c))) lane_cnt[c] = lane_cnt[c] + LCW'(1);
            end
        end
        // 7-bit compare so NUM_CHANNELS = 64 never flags anything
        for (int l = 0; l < LANES; l++) begin
            if (s1_vld_q[l] && ({1'b0, s1_ch_q[l]} >= 7'(NUM_CHANNELS))) oor_cnt = oor_cnt + LCW'(1);
        end
    end

    assign en     = control_q[0];
    assign expire = (timer_q == 32'd0);

    always_comb begin
        logic [CNT_WIDTH:0] sum;
        sum = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sum = {1'b0, rate_q[c]} + (CNT_WIDTH+1)'(en ? lane_cnt[c] : LCW'(0));
            rate_sat[c] = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
        end
    end

    assign req       = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
    assign wr        = req & bus.wb_we_i;
    assign adr_w     = 32'(bus.wb_adr_i) & 32'hFFFF_FFFC;
    assign gate_wval = (bus.wb_dat_i < GATE_MIN) ? GATE_MIN : bus.wb_dat_i;

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            total_d[c]   = clr_q[0] ? '0 : (en ? total_q[c] + CNT_WIDTH'(lane_cnt[c]) : total_q[c]);
            rate_d[c]    = (clr_q[2] || expire) ? '0 : rate_sat[c];
            latched_d[c] = (expire && !control_q[1]) ? rate_sat[c] : latched_q[c];
        end
        oor_d     = clr_q[0] ? '0 : (en ? oor_q + CNT_WIDTH'(oor_cnt) : oor_q);
        // a set arriving with a clear wins
        ovf_d     = s1_ovf_q | (ovf_q & ~clr_q[1]);
        control_d = (wr && adr_w == 32'h04) ? bus.wb_dat_i[1:0] : control_q;
        clr_d     = (wr && adr_w == 32'h08) ? bus.wb_dat_i[2:0] : 3'b000;
        gate_d    = (wr && adr_w == 32'h0C) ? gate_wval : gate_q;
        if (wr && adr_w == 32'h0C)  timer_d = gate_wval;
        else if (clr_q[2] || expire) timer_d = gate_q;
        else                         timer_d = timer_q - 32'd1;
    end

    always_comb begin
        rdata = 32'd0;
        case (adr_w)
            32'h00:  rdata = 32'd2;
            32'h04:  rdata = {30'd0, control_q};
            32'h0C:  rdata = gate_q;
            32'h10:  rdata = 32'(NUM_CHANNELS);
            32'h14:  rdata = {31'd0, ovf_q};
            32'h18:  rdata = 32'(oor_q);
            default: begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    if (adr_w == 32'(64 + 8*c)) rdata = 32'(total_q[c]);
                    if (adr_w == 32'(68 + 8*c)) rdata = 32'(latched_q[c]);
                end
            end
        endcase
        ack_d = req;
        dat_d = (req && !bus.wb_we_i) ? rdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= '0;
            s1_ovf_q  <= 1'b0;
            for (int l = 0; l < LANES; l++) s1_ch_q[l] <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                total_q[c]   <= '0;
                rate_q[c]    <= '0;
                latched_q[c] <= '0;
            end
            oor_q     <= '0;
            ovf_q     <= 1'b0;
            control_q <= 2'b01;
            clr_q     <= 3'b000;
            gate_q    <= GATE_RST;
            timer_q   <= GATE_RST;
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_ovf_q  <= s1_ovf_d;
            for (int l = 0; l < LANES; l++) s1_ch_q[l] <= s1_ch_d[l];
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                total_q[c]   <= total_d[c];
                rate_q[c]    <= rate_d[c];
                latched_q[c] <= latched_d[c];
            end
            oor_q     <= oor_d;
            ovf_q     <= ovf_d;
            control_q <= control_d;
            clr_q     <= clr_d;
            gate_q    <= gate_d;
            timer_q   <= timer_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign bus.wb_ack_o = ack_q;
    assign bus.wb_dat_o = dat_q;
endmodule

// File: tb/tb_si_channel_statistics_wb.sv
// Directed bench for si_channel_statistics_wb; CNT_WIDTH=16 keeps the wrap scenario short.
module tb_si_channel_statistics_wb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    si_channel_statistics_wb_if #(.DATA_WIDTH(128), .KEEP_WIDTH(16), .ADDR_WIDTH(10)) bus ();

    si_channel_statistics_wb #(
        .DATA_WIDTH(128), .KEEP_WIDTH(16), .NUM_CHANNELS(8), .CNT_WIDTH(16),
        .CLK_FREQ(333333333), .ADDR_WIDTH(10)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] ttag(input int ch);
        return {2'b01, 6'(ch), 24'h00ABCD};
    endfunction

    function automatic logic [127:0] four(input int c0, input int c1, input int c2, input int c3);
        return {ttag(c3), ttag(c2), ttag(c1), ttag(c0)};
    endfunction

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output int lat, output logic late_ack);
        bus.wb_adr_i = a[9:0]; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.wb_ack_o && lat < 8);
        d = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(negedge clk);
        late_ack = bus.wb_ack_o;
        if (lat >= 8) begin
            vectors++; miscompares++;
            $display("FAIL wb_read_timeout addr=%h: no ack within 8 cycles", a);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        int lat;
        bus.wb_adr_i = a[9:0]; bus.wb_dat_i = d; bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.wb_ack_o && lat < 8);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        @(negedge clk);
        if (lat >= 8) begin
            vectors++; miscompares++;
            $display("FAIL wb_write_timeout addr=%h: no ack within 8 cycles", a);
        end
    endtask

    task automatic beat(input logic [127:0] d, input logic [15:0] k);
        bus.axis_tdata = d; bus.axis_tkeep = k; bus.axis_tvalid = 1'b1; bus.axis_tready = 1'b1;
        @(negedge clk);
        bus.axis_tvalid = 1'b0;
    endtask

    // beat and reset-register write presented in the same cycle
    task automatic beat_with_clear(input logic [127:0] d, input logic [15:0] k, input logic [31:0] clr);
        bus.axis_tdata = d; bus.axis_tkeep = k; bus.axis_tvalid = 1'b1; bus.axis_tready = 1'b1;
        bus.wb_adr_i = 10'h008; bus.wb_dat_i = clr; bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(negedge clk);
        bus.axis_tvalid = 1'b0;
        vectors++;
        if (bus.wb_ack_o !== 1'b1) begin miscompares++; $display("FAIL clr_ack: got %b want 1", bus.wb_ack_o); end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d; int lat; logic la;
        rst = 1'b1;
        bus.axis_tvalid = 1'b0; bus.axis_tready = 1'b0; bus.axis_tdata = '0; bus.axis_tkeep = '0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (bus.wb_ack_o !== 1'b0) begin miscompares++; $display("FAIL rst_ack: got %b want 0", bus.wb_ack_o); end
        vectors++; if (bus.wb_dat_o !== 32'd0) begin miscompares++; $display("FAIL rst_dat: got %h want 0", bus.wb_dat_o); end
        wb_read(32'h00, d, lat, la);
        vectors++; if (d !== 32'd2) begin miscompares++; $display("FAIL presence: got %0d want 2", d); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL ack_latency: got %0d want 1", lat); end
        vectors++; if (la !== 1'b0) begin miscompares++; $display("FAIL ack_width: got %b want 0", la); end
        wb_read(32'h10, d, lat, la);
        vectors++; if (d !== 32'd8) begin miscompares++; $display("FAIL num_channels: got %0d want 8", d); end
        wb_read(32'h0C, d, lat, la);
        vectors++; if (d !== 32'd333333332) begin miscompares++; $display("FAIL gate_reset: got %0d want 333333332", d); end
        wb_read(32'h04, d, lat, la);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL control_reset: got %0d want 1", d); end
        wb_read(32'h58, d, lat, la);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL total3_reset: got %0d want 0", d); end
    endtask

    task automatic test_single_beat;
        logic [31:0] d; int lat; logic la;
        beat(four(3, 3, 5, 3), 16'hFFFF);
        wb_read(32'h58, d, lat, la);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL total3_early: got %0d want 0", d); end
        wb_read(32'h58, d, lat, la);
        vectors++; if (d !== 32'd3) begin miscompares++; $display("FAIL total3: got %0d want 3", d); end
        wb_read(32'h68, d, lat, la);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL total5: got %0d want 1", d); end
        // ready low is not a beat; only keep bit 4i+3 qualifies a lane
        bus.axis_tdata = four(3, 3, 3, 3); bus.axis_tkeep = 16'hFFFF; bus.axis_tvalid = 1'b1; bus.axis_tready = 1'b0;
        @(negedge clk);
        bus.axis_tvalid = 1'b0;
        beat(four(5, 5, 5, 5), 16'h0087);
        repeat (2) @(negedge clk);
        wb_read(32'h58, d, lat, la);
        vectors++; if (d !== 32'd3) begin miscompares++; $display("FAIL total3_noready: got %0d want 3", d); end
        wb_read(32'h68, d, lat, la);
        vectors++; if (d !== 32'd2) begin miscompares++; $display("FAIL total5_keep: got %0d want 2", d); end
    endtask

    task automatic test_gate_rate;
        logic [31:0] d; int lat; logic la;
        wb_write(32'h0C, 32'd3);
        wb_read(32'h0C, d, lat, la);
        vectors++; if (d !== 32'd15) begin miscompares++; $display("FAIL gate_clamp: got %0d want 15", d); end
        wb_write(32'h0C, 32'd99);
        wb_read(32'h0C, d, lat, la);
        vectors++; if (d !== 32'd99) begin miscompares++; $display("FAIL gate_write: got %0d want 99", d); end
        bus.axis_tdata = four(0, 0, 0, 0); bus.axis_tkeep = 16'h000F; bus.axis_tvalid = 1'b1; bus.axis_tready = 1'b1;
        repeat (1000) @(negedge clk);
        wb_read(32'h44, d, lat, la);
        bus.axis_tvalid = 1'b0;
        vectors++; if (d !== 32'd100) begin miscompares++; $display("FAIL rate0_run: got %0d want 100", d); end
        repeat (250) @(negedge clk);
        wb_read(32'h44, d, lat, la);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL rate0_stall: got %0d want 0", d); end
        wb_read(32'h40, d, lat, la);
        vectors++; if (d !== 32'd1002) begin miscompares++; $display("FAIL total0_run: got %0d want 1002", d); end
    endtask

    task automatic test_overflow_oor;
        logic [31:0] d; int lat; logic la;
        beat({32'd0, 32'd0, {2'b11, 6'd3, 24'd0}, 32'h8000_0000}, 16'h0088);
        repeat (2) @(negedge clk);
        wb_read(32'h14, d, lat, la);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL overflow_set: got %0d want 1", d); end
        wb_read(32'h58, d, lat, la);
        vectors++; if (d !== 32'd3) begin miscompares++; $display("FAIL total3_type11: got %0d want 3", d); end
        wb_write(32'h08, 32'h2);
        wb_read(32'h14, d, lat, la);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL overflow_clear: got %0d want 0", d); end
        beat_with_clear({96'd0, 32'h8000_0000}, 16'h0008, 32'h2);
        wb_read(32'h14, d, lat, la);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL overflow_set_wins: got %0d want 1", d); end
        wb_write(32'h08, 32'h2);
        beat(four(9, 0, 0, 0), 16'h0008);
        repeat (2) @(negedge clk);
        wb_read(32'h18, d, lat, la);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL out_of_range: got %0d want 1", d); end
        wb_read(32'h88, d, lat, la);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL total9_unmapped: got %0d want 0", d); end
        wb_read(32'h14, d, lat, la);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL overflow_after: got %0d want 0", d); end
    endtask

    task automatic test_wrap_clear;
        logic [31:0] d; int lat; logic la;
        wb_write(32'h08, 32'h1);
        wb_read(32'h18, d, lat, la);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL oor_clear: got %0d want 0", d); end
        bus.axis_tdata = four(1, 1, 1, 1); bus.axis_tkeep = 16'hFFFF; bus.axis_tvalid = 1'b1; bus.axis_tready = 1'b1;
        repeat (16383) @(negedge clk);
        bus.axis_tkeep = 16'h0FFF;
        @(negedge clk);
        bus.axis_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        wb_read(32'h48, d, lat, la);
        vectors++; if (d !== 32'h0000FFFF) begin miscompares++; $display("FAIL total1_max: got %h want 0000ffff", d); end
        beat(four(1, 1, 1, 1), 16'h00FF);
        repeat (2) @(negedge clk);
        wb_read(32'h48, d, lat, la);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL total1_wrap: got %0d want 1", d); end
        beat_with_clear(four(1, 1, 1, 1), 16'hFFFF, 32'h1);
        wb_read(32'h48, d, lat, la);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL total1_clear_wins: got %0d want 0", d); end
    endtask

    task automatic test_control;
        logic [31:0] d; int lat; logic la;
        logic [127:0] mix;
        mix = {32'h8000_0000, ttag(2), ttag(9), ttag(2)};
        wb_write(32'h04, 32'h0);
        wb_read(32'h04, d, lat, la);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL control_rd: got %0d want 0", d); end
        bus.axis_tdata = mix; bus.axis_tkeep = 16'hFFFF; bus.axis_tvalid = 1'b1; bus.axis_tready = 1'b1;
        repeat (10) @(negedge clk);
        bus.axis_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        wb_read(32'h50, d, lat, la);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL total2_disabled: got %0d want 0", d); end
        wb_read(32'h18, d, lat, la);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL oor_disabled: got %0d want 0", d); end
        wb_read(32'h14, d, lat, la);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL overflow_disabled: got %0d want 1", d); end
        wb_write(32'h04, 32'h1);
        beat(mix, 16'hFFFF);
        repeat (2) @(negedge clk);
        wb_read(32'h50, d, lat, la);
        vectors++; if (d !== 32'd2) begin miscompares++; $display("FAIL total2_enabled: got %0d want 2", d); end
        wb_read(32'h18, d, lat, la);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL oor_enabled: got %0d want 1", d); end
        bus.axis_tdata = four(0, 0, 0, 0); bus.axis_tkeep = 16'h000F; bus.axis_tvalid = 1'b1; bus.axis_tready = 1'b1;
        repeat (300) @(negedge clk);
        wb_read(32'h44, d, lat, la);
        vectors++; if (d !== 32'd100) begin miscompares++; $display("FAIL rate0_prefreeze: got %0d want 100", d); end
        wb_write(32'h04, 32'h3);
        bus.axis_tvalid = 1'b0;
        repeat (250) @(negedge clk);
        wb_read(32'h44, d, lat, la);
        vectors++; if (d !== 32'd100) begin miscompares++; $display("FAIL rate0_frozen: got %0d want 100", d); end
        wb_write(32'h04, 32'h1);
        repeat (250) @(negedge clk);
        wb_read(32'h44, d, lat, la);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL rate0_unfrozen: got %0d want 0", d); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_gate_rate();
        test_overflow_oor();
        test_wrap_clear();
        test_control();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
